// File: rtl/fdma_reset_sched.sv
// Frame-synchronous reset scheduler: after each field-sync falling edge, holds and resets each enabled FDMA channel in turn.
// Optional macro FDMA_RST_SCHED_RESTART_EN: a falling edge seen during DELAY restarts the blanking delay.
module fdma_reset_sched #(
    parameter int CH_NUM       = 2,
    parameter int RST_DELAY    = 512,
    parameter int RST_PERIOD   = 30,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic              i_Sys_clk,
    input  logic              i_Rst_n,
    input  logic              i_Field_sync,
    input  logic [CH_NUM-1:0] i_Ch_en,
    input  logic [CH_NUM-1:0] i_Ch_idle,
    output logic [CH_NUM-1:0] o_Ch_hold,
    output logic [CH_NUM-1:0] o_Axi_reset,
    output logic              o_Busy,
    output logic [7:0]        o_Timeout_cnt
);

    localparam int MAX_A   = (RST_DELAY > RST_PERIOD) ? RST_DELAY : RST_PERIOD;
    localparam int MAX_CNT = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(CH_NUM + 1);
    localparam int PW      = 2 ** IW;

    localparam logic [CW-1:0] DELAY_LAST = CW'(RST_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] RESET_LAST = CW'(RST_PERIOD - 1);
    localparam logic [IW-1:0] IDX_END    = IW'(CH_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_SELECT,
        S_HOLD,
        S_RESET,
        S_RELEASE
    } state_t;

    state_t            state, state_next;
    logic [IW-1:0]     ch_idx, idx_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [7:0]        tmo_next;
    logic              sync_d1, sync_d2;
    logic              neg;
    logic [PW-1:0]     en_pad, idle_pad;
    logic [CH_NUM-1:0] ch_oh;

    assign neg = ~sync_d1 & sync_d2;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        idx_next   = ch_idx;
        cnt_next   = cnt;
        tmo_next   = o_Timeout_cnt;
        en_pad     = '0;
        idle_pad   = '0;
        en_pad[CH_NUM-1:0]   = i_Ch_en;
        idle_pad[CH_NUM-1:0] = i_Ch_idle;

        case (state)
            S_IDLE: begin
                if (neg) begin
                    state_next = S_DELAY;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            S_DELAY: begin
                if (cnt == DELAY_LAST) begin
                    state_next = S_SELECT;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
`ifdef FDMA_RST_SCHED_RESTART_EN
                if (neg) begin
                    state_next = S_DELAY;
                    cnt_next   = '0;
                end
`endif
            end
            S_SELECT: begin
                if (ch_idx == IDX_END) begin
                    state_next = S_IDLE;
                end else if (en_pad[ch_idx]) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end else begin
                    idx_next = ch_idx + IW'(1);
                end
            end
            S_HOLD: begin
                // Idle wins over a coincident last count, so no timeout is logged then.
                if (idle_pad[ch_idx]) begin
                    state_next = S_RESET;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = S_RESET;
                    cnt_next   = '0;
                    if (o_Timeout_cnt != 8'hFF)
                        tmo_next = o_Timeout_cnt + 8'd1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_RESET: begin
                if (cnt == RESET_LAST) begin
                    state_next = S_RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                state_next = S_SELECT;
                idx_next   = ch_idx + IW'(1);
            end
            default: state_next = S_IDLE;
        endcase

        // Shifting past the top bit (idx == CH_NUM) yields zero, which is only used while IDLE.
        ch_oh = CH_NUM'(1) << idx_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_Sys_clk) begin
        if (!i_Rst_n) begin
            state         <= S_IDLE;
            ch_idx        <= '0;
            cnt           <= '0;
            sync_d1       <= 1'b0;
            sync_d2       <= 1'b0;
            o_Ch_hold     <= '0;
            o_Axi_reset   <= '0;
            o_Busy        <= 1'b0;
            o_Timeout_cnt <= '0;
        end else begin
            state         <= state_next;
            ch_idx        <= idx_next;
            cnt           <= cnt_next;
            sync_d1       <= i_Field_sync;
            sync_d2       <= sync_d1;
            // Outputs are decoded from the next state so they align with the state's own cycles.
            o_Busy        <= (state_next != S_IDLE);
            o_Ch_hold     <= (state_next == S_HOLD || state_next == S_RESET) ? ch_oh : '0;
            o_Axi_reset   <= (state_next == S_RESET) ? ch_oh : '0;
            o_Timeout_cnt <= tmo_next;
        end
    end

endmodule

// File: doc/fdma_reset_sched.md
Name: fdma_reset_sched

Overview:
- Frame-synchronous reset scheduler for a multi-channel FDMA subsystem.
- On each i_Field_sync falling edge it waits a fixed blanking delay. It then visits each enabled channel in ascending index order.
- For each visited channel it: asserts hold (master blocks new bursts), waits for the channel to report idle or for a timeout, drives that channel's AXI reset for a fixed period, then releases it.
- Only one channel is ever held or reset at a time. Sits between the video timing generator and the per-channel FDMA read/write controllers.

Parameters:
- CH_NUM, 2: number of FDMA channels (1..8).
- RST_DELAY, 512: cycles spent in DELAY after the detected falling edge (≥1).
- RST_PERIOD, 30: cycles o_Axi_reset[k] stays high per channel (≥1).
- IDLE_TIMEOUT, 1024: maximum cycles in HOLD waiting for idle (≥1).

Ports:
- i_Sys_clk  in  1  system clock; sole clock.
- i_Rst_n  in  1  synchronous active-low reset, sampled on i_Sys_clk rising edge.
- i_Field_sync  in  1  field/frame sync, level; falling edge starts a sequence.
- i_Ch_en  in  CH_NUM  per-channel enable; bit k=0 skips channel k.
- i_Ch_idle  in  CH_NUM  per-channel "no outstanding AXI transaction".
- o_Ch_hold  out  CH_NUM  registered; 1 = channel must not issue new bursts.
- o_Axi_reset  out  CH_NUM  registered; active-high reset to channel's AXI controller.
- o_Busy  out  1  registered; 1 whenever FSM not in IDLE.
- o_Timeout_cnt  out  8  registered; saturating count of HOLD exits by timeout.

Behaviour:
- Reset: i_Rst_n=0 at a clock edge gives FSM=IDLE, ch_idx=0, all counters 0, sync delay regs 0, all outputs 0. Reset mid-sequence aborts immediately; no partial reset pulse is completed.
- Edge detect: two-flop delay d1<=i_Field_sync, d2<=d1. neg = ~d1 & d2 (combinational). neg in cycle T while IDLE: FSM=DELAY at T+1.
- DELAY: counter 0..RST_DELAY-1, exactly RST_DELAY cycles. Then SELECT with ch_idx=0.
- SELECT: one cycle per visited index.
  - ch_idx==CH_NUM: go IDLE.
  - else i_Ch_en[ch_idx]=1 (sampled this cycle): go HOLD.
  - else: ch_idx+1, stay SELECT.
- HOLD: o_Ch_hold[ch_idx]=1; wait counter 0..IDLE_TIMEOUT-1. Minimum 1 cycle.
  - i_Ch_idle[ch_idx]=1 sampled in any HOLD cycle: go RESET.
  - else at counter==IDLE_TIMEOUT-1: go RESET and increment o_Timeout_cnt (saturates at 255).
  - Idle and last-count in the same cycle count as idle; no timeout increment.
- RESET: o_Ch_hold[ch_idx]=1 and o_Axi_reset[ch_idx]=1 for exactly RST_PERIOD cycles. Then RELEASE.
- RELEASE: one cycle, all hold/reset bits 0; ch_idx+1, go SELECT.
- Output timing: outputs are flops, high exactly during the cycles the FSM occupies the named state. At most one bit of o_Ch_hold and at most one bit of o_Axi_reset set at any time.
- Other inputs:
  - i_Ch_en changes outside SELECT have no effect on the current channel.
  - i_Ch_idle is ignored outside HOLD.
- Falling edge while not IDLE: ignored, except as given under Optional Feature.
- Falling edge in the same cycle the FSM returns to IDLE: ignored. A falling edge seen while IDLE starts a new sequence.
- Widths: counters sized $clog2 of max(RST_DELAY, RST_PERIOD, IDLE_TIMEOUT)+1; ch_idx sized $clog2(CH_NUM+1).

Optional Feature:
- Macro FDMA_RST_SCHED_RESTART_EN.
- Defined: a falling edge detected while in DELAY clears the delay counter, so the full RST_DELAY restarts from the cycle after that edge. Edges in SELECT/HOLD/RESET/RELEASE are still ignored.
- Undefined: all edges outside IDLE are ignored, DELAY included.

Test Plan:
- Nominal: CH_NUM=2, RST_DELAY=8, RST_PERIOD=4, IDLE_TIMEOUT=16, i_Ch_en=2'b11, i_Ch_idle=2'b11, neg at cycle T -> o_Busy high T+1..T+23; o_Ch_hold[0] high T+10..T+14; o_Axi_reset[0] high T+11..T+14; o_Ch_hold[1] high T+17..T+21; o_Axi_reset[1] high T+18..T+21; o_Timeout_cnt=0.
- Timeout: same params, i_Ch_idle[0]=0 always -> o_Ch_hold[0] high for 16+4=20 cycles; o_Axi_reset[0] high 4 cycles after those 16; o_Timeout_cnt=1. Repeat 300 frames -> o_Timeout_cnt stays 255.
- Skip: i_Ch_en=2'b10 -> channel 0 outputs stay 0; o_Ch_hold[1] rises at T+11 (two SELECT cycles).
- Late idle: i_Ch_idle[1] rises on 5th HOLD cycle -> RESET starts next cycle; no timeout increment.
- Mid-sequence: i_Rst_n=0 during RESET of ch0 -> all outputs 0 on next edge. A second neg during DELAY (macro off) gives an unchanged schedule; with FDMA_RST_SCHED_RESTART_EN, a second neg at T+5 shifts every later event by 5 cycles.
